// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and flow control for a five-stage pipeline.
// Produces per-stage stall/flush from load-use, mult/div occupancy,
// memory wait, taken branches and jumps. Stall and flush are combinational
// from the current state and inputs, so they take effect in the same cycle.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the saturating stall and
// flush performance counters. When it is not defined, both counter ports
// read 0 and no counter flops exist.
module pipe_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        md_start,
  input  logic        mem_busy,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        md_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic {RUN, MD} state_t;

  // cnt counts down the remaining EX cycles of a mult/div; the start cycle
  // is the first of MD_LATENCY, so the count begins at MD_LATENCY-1.
  localparam logic [5:0] CNT_INIT = 6'(MD_LATENCY - 1);

  state_t     state;
  logic [5:0] cnt;

  logic load_use;
  logic md_hold;
  logic md_finish;

  // Hazard terms: load-use match (register 0 never hazards), mult/div
  // holding EX this cycle, and the mult/div final cycle.
  always_comb begin
    load_use  = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
    md_hold   = ((state == RUN) && md_start) ||
                ((state == MD) && (cnt != 6'd1));
    md_finish = (state == MD) && (cnt == 6'd1) && !mem_busy;
  end

  // Stall/flush priority: mem wait > mult/div hold > branch > load-use > jump.
  // A mult/div hold sets stall[2], which suppresses the branch; any stall of
  // ID sets stall[1], which suppresses the jump.
  always_comb begin
    stall   = 5'b00000;
    flush   = 5'b00000;
    md_done = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        stall = 5'b01111;
      end else begin
        md_done = md_finish;
        if (md_hold) begin
          stall = 5'b00111;
        end else if (ex_branch_taken) begin
          flush = 5'b00011;
        end else if (load_use) begin
          stall = 5'b00011;
        end else if (id_jump) begin
          flush = 5'b00001;
        end
      end
    end
  end

  // Mult/div FSM: state and cnt are frozen whenever memory is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else if (!mem_busy) begin
      case (state)
        RUN: begin
          if (md_start) begin
            cnt   <= CNT_INIT;
            state <= MD;
          end
        end
        MD: begin
          if (cnt == 6'd1) begin
            cnt   <= 6'd0;
            state <= RUN;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        default: begin
          cnt   <= 6'd0;
          state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating performance counters: cycles with IF stalled, cycles with any flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((flush != 5'b00000) && (flush_events != 32'hFFFF_FFFF)) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32, meaning total EX-occupancy cycles of a mult/div op (legal 2..63).
REQ-002 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_rs  input  5  Rs of the instruction in ID.
REQ-005 SHALL have port id_rt  input  5  Rt of the instruction in ID.
REQ-006 SHALL have port ex_rt  input  5  Rt of the instruction in EX.
REQ-007 SHALL have port ex_memread  input  1  EX instruction is a load.
REQ-008 SHALL have port ex_branch_taken  input  1  EX branch resolved taken.
REQ-009 SHALL have port id_jump  input  1  ID instruction is a jump.
REQ-010 SHALL have port md_start  input  1  EX instruction is a mult/div.
REQ-011 SHALL have port mem_busy  input  1  data memory not ready this cycle.
REQ-012 SHALL have port stall  output  5  per-stage hold, bit 0 IF .. bit 4 WB.
REQ-013 SHALL have port flush  output  5  per-stage squash, bit k clears the register fed by stage k.
REQ-014 SHALL have port md_done  output  1  one-cycle pulse when mult/div releases EX.
REQ-015 SHALL have ports stall_cycles and flush_events  output  32 each  performance counters.

Function
REQ-016 SHALL keep stall monotonic: stall[k]=1 implies stall[j]=1 for all j<k.
REQ-017 SHALL use states RUN and MD, plus a 6-bit down-counter cnt.
REQ-018 SHALL detect load-use as ex_memread && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt), driving stall=00011 combinationally that cycle.
REQ-019 SHALL, on md_start in RUN, drive stall=00111 that cycle, load cnt=MD_LATENCY-1, and go to MD.
REQ-020 SHALL, in MD, ignore md_start, drive stall=00111 while cnt!=1, and decrement cnt each non-mem_busy cycle.
REQ-021 SHALL, in MD with cnt==1 and mem_busy=0, drive stall=00000, pulse md_done, and return to RUN next edge.
REQ-022 SHALL drive stall=01111 whenever mem_busy=1, overriding all other stall sources, with cnt and state frozen.
REQ-023 SHALL drive flush=00011 on ex_branch_taken when stall[2]=0; when stall[2]=1 the branch is suppressed.
REQ-024 SHALL drive flush=00001 on id_jump when stall[1]=0 and no branch flush is active.
REQ-025 SHALL let a branch flush win over a same-cycle load-use, suppressing that stall.
REQ-026 SHALL let a load-use stall win over a same-cycle jump, suppressing that flush.
REQ-027 SHALL drive stall and flush combinationally from state and inputs, with zero latency.

Reset
REQ-028 SHALL, while reset=1, force state=RUN, cnt=0, stall=0, flush=0, md_done=0, and counters=0.
REQ-029 SHALL abandon a mult/div in progress when reset asserts, with no md_done pulse.

Configuration
REQ-030 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cycles on each cycle with stall[0]=1, saturating at 32'hFFFFFFFF.
REQ-031 SHALL, with PIPE_CTRL_PERF_EN defined, increment flush_events on each cycle with flush!=0, saturating at 32'hFFFFFFFF.
REQ-032 SHALL, with PIPE_CTRL_PERF_EN undefined, keep both counter ports present and tied to 0, with no counter flops.

Verification
REQ-033 SHALL cover load-use: ex_memread=1, ex_rt=5, id_rs=5 -> stall=00011 for one cycle, flush=0.
REQ-034 SHALL cover mult/div: MD_LATENCY=4, md_start at cycle 0 -> stall=00111 on cycles 0-2, stall=0 and md_done=1 on cycle 3.
REQ-035 SHALL cover memory wait: mem_busy=1 for cycles 1-2 during REQ-034 -> stall=01111 on cycles 1-2, md_done moves to cycle 5.
REQ-036 SHALL cover branch vs load-use: ex_branch_taken=1 with a load-use match -> flush=00011, stall=0.
REQ-037 SHALL cover jump and load register 0: id_jump=1, no hazard -> flush=00001; ex_memread=1, ex_rt=0, id_rs=0 -> stall=0.
REQ-038 SHALL cover reset mid-MD: reset at cycle 1 of REQ-034 -> all outputs 0, RUN, no md_done.
